// File: rtl/reg_file_wb_pkg.sv
// reg_file_wb_pkg: shared defaults, types and constants for the write-back
// register file.
//   W_DEFAULT / NREGS_DEFAULT : default data width and register count
//   word_t / regaddr_t        : data word and register address at the defaults
//   R0_ADDR                   : address of the accumulator register R0
//   WCOUNT_MAX                : saturation value of the write counter
package reg_file_wb_pkg;

    localparam int W_DEFAULT     = 8;
    localparam int NREGS_DEFAULT = 8;
    localparam int AW_DEFAULT    = $clog2(NREGS_DEFAULT);

    typedef logic [W_DEFAULT-1:0]  word_t;
    typedef logic [AW_DEFAULT-1:0] regaddr_t;

    localparam int         R0_ADDR    = 0;
    localparam logic [7:0] WCOUNT_MAX = 8'd255;

endpackage

// File: rtl/reg_file_wb_rf_bypass.sv
// rf_bypass: combinational forwarding selector for one register-file read port.
//   fwd_en   : forwarding allowed this cycle (off when bypass disabled or in reset)
//   rd_addr  : address being read
//   stored   : value currently held in the array at rd_addr
//   wr_en / wr_addr / wr_data : general write port
//   r0_en / r0_data           : dedicated R0 write port
//   rd_data  : value presented on the read port
module rf_bypass
    import reg_file_wb_pkg::*;
#(
    parameter int W  = W_DEFAULT,
    parameter int AW = AW_DEFAULT
) (
    input  logic          fwd_en,
    input  logic [AW-1:0] rd_addr,
    input  logic [W-1:0]  stored,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          r0_en,
    input  logic [W-1:0]  r0_data,
    output logic [W-1:0]  rd_data
);

    // General port is checked first so that a collision on R0 forwards the
    // same value the array will actually commit.
    always_comb begin
        rd_data = stored;
        if (fwd_en) begin
            if (wr_en && (rd_addr == wr_addr)) begin
                rd_data = wr_data;
            end else if (r0_en && (rd_addr == AW'(R0_ADDR))) begin
                rd_data = r0_data;
            end
        end
    end

endmodule

// File: rtl/reg_file_wb.sv
// reg_file_wb: architectural register file fed by the write-back select mux.
//   Clk, Reset              : clock and synchronous active-high reset
//   ReadReg1 / ReadData1    : addressed read port (mux Source2 path)
//   ReadR0                  : dedicated R0 read (mux Source1 path)
//   WriteEn/WriteReg/WriteValue : general write-back port
//   R0WriteEn / R0Value     : dedicated R0 accumulator write port
//   WriteCount              : committed-write edges since reset, saturating at 255
module reg_file_wb
    import reg_file_wb_pkg::*;
#(
    parameter int   W      = W_DEFAULT,
    parameter int   NREGS  = NREGS_DEFAULT,
    parameter int   BYPASS = 1,
    localparam int  AW     = $clog2(NREGS)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic [AW-1:0] ReadReg1,
    input  logic          WriteEn,
    input  logic [AW-1:0] WriteReg,
    input  logic [W-1:0]  WriteValue,
    input  logic          R0WriteEn,
    input  logic [W-1:0]  R0Value,
    output logic [W-1:0]  ReadR0,
    output logic [W-1:0]  ReadData1,
    output logic [7:0]    WriteCount
);

    logic [W-1:0] regs_q [NREGS];
    logic [W-1:0] regs_d [NREGS];
    logic [7:0]   write_count_q;
    logic [7:0]   write_count_d;
    logic         fwd_en;

    always_comb begin
        regs_d = regs_q;
        // R0 port first so a general write to address 0 overrides it.
        if (R0WriteEn) begin
            regs_d[R0_ADDR] = R0Value;
        end
        if (WriteEn) begin
            regs_d[WriteReg] = WriteValue;
        end

        // A collision still counts as a single committed write.
        write_count_d = write_count_q;
        if ((WriteEn || R0WriteEn) && (write_count_q != WCOUNT_MAX)) begin
            write_count_d = write_count_q + 8'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            write_count_q <= '0;
        end else begin
            regs_q        <= regs_d;
            write_count_q <= write_count_d;
        end
    end

    // In reset the pending writes are discarded, so forwarding them would lie.
    assign fwd_en = (BYPASS != 0) && !Reset;

    rf_bypass #(.W(W), .AW(AW)) u_byp_r0 (
        .fwd_en  (fwd_en),
        .rd_addr (AW'(R0_ADDR)),
        .stored  (regs_q[R0_ADDR]),
        .wr_en   (WriteEn),
        .wr_addr (WriteReg),
        .wr_data (WriteValue),
        .r0_en   (R0WriteEn),
        .r0_data (R0Value),
        .rd_data (ReadR0)
    );

    rf_bypass #(.W(W), .AW(AW)) u_byp_rd1 (
        .fwd_en  (fwd_en),
        .rd_addr (ReadReg1),
        .stored  (regs_q[ReadReg1]),
        .wr_en   (WriteEn),
        .wr_addr (WriteReg),
        .wr_data (WriteValue),
        .r0_en   (R0WriteEn),
        .r0_data (R0Value),
        .rd_data (ReadData1)
    );

    assign WriteCount = write_count_q;

endmodule

// File: tb/tb_reg_file_wb.sv
// tb_reg_file_wb: directed bench driving a BYPASS=0 and a BYPASS=1 instance of
// reg_file_wb from the same stimulus and comparing both against hand values.
module tb_reg_file_wb;

    logic       Clk;
    logic       Reset;
    logic [2:0] ReadReg1;
    logic       WriteEn;
    logic [2:0] WriteReg;
    logic [7:0] WriteValue;
    logic       R0WriteEn;
    logic [7:0] R0Value;

    logic [7:0] r0_nb, rd1_nb, cnt_nb;
    logic [7:0] r0_b,  rd1_b,  cnt_b;

    int errors = 0;
    int checks = 0;

    reg_file_wb #(.W(8), .NREGS(8), .BYPASS(0)) u_nb (
        .Clk(Clk), .Reset(Reset), .ReadReg1(ReadReg1),
        .WriteEn(WriteEn), .WriteReg(WriteReg), .WriteValue(WriteValue),
        .R0WriteEn(R0WriteEn), .R0Value(R0Value),
        .ReadR0(r0_nb), .ReadData1(rd1_nb), .WriteCount(cnt_nb)
    );

    reg_file_wb #(.W(8), .NREGS(8), .BYPASS(1)) u_b (
        .Clk(Clk), .Reset(Reset), .ReadReg1(ReadReg1),
        .WriteEn(WriteEn), .WriteReg(WriteReg), .WriteValue(WriteValue),
        .R0WriteEn(R0WriteEn), .R0Value(R0Value),
        .ReadR0(r0_b), .ReadData1(rd1_b), .WriteCount(cnt_b)
    );

    initial Clk = 1'b0;
    always #10 Clk = ~Clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then changed and outputs
    // sampled well before the following edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        WriteEn   = 1'b0;
        R0WriteEn = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; ReadReg1 = '0; WriteEn = 1'b0; WriteReg = '0;
        WriteValue = '0; R0WriteEn = 1'b0; R0Value = '0;

        // Reset then idle: everything reads zero.
        tick();
        Reset = 1'b0;
        for (int a = 0; a < 8; a++) begin
            ReadReg1 = 3'(a);
            #1;
            check($sformatf("rst_rd1_nb[%0d]", a), rd1_nb, 8'h00);
            check($sformatf("rst_rd1_b[%0d]", a), rd1_b, 8'h00);
        end
        check("rst_r0_nb", r0_nb, 8'h00);
        check("rst_r0_b", r0_b, 8'h00);
        check("rst_cnt_nb", cnt_nb, 8'h00);
        check("rst_cnt_b", cnt_b, 8'h00);

        // Basic write to reg3: stored value unchanged until the edge, bypass forwards.
        WriteEn = 1'b1; WriteReg = 3'd3; WriteValue = 8'hA5; ReadReg1 = 3'd3;
        #1;
        check("wr3_same_nb", rd1_nb, 8'h00);
        check("wr3_same_b", rd1_b, 8'hA5);
        tick();
        idle_inputs();
        #1;
        check("wr3_next_nb", rd1_nb, 8'hA5);
        check("wr3_next_b", rd1_b, 8'hA5);
        check("wr3_cnt_nb", cnt_nb, 8'd1);
        check("wr3_cnt_b", cnt_b, 8'd1);

        // Collision on R0: general port wins, one count.
        WriteEn = 1'b1; WriteReg = 3'd0; WriteValue = 8'h11;
        R0WriteEn = 1'b1; R0Value = 8'h22; ReadReg1 = 3'd0;
        #1;
        check("col_same_r0_nb", r0_nb, 8'h00);
        check("col_same_r0_b", r0_b, 8'h11);
        check("col_same_rd1_b", rd1_b, 8'h11);
        tick();
        idle_inputs();
        #1;
        check("col_next_r0_nb", r0_nb, 8'h11);
        check("col_next_r0_b", r0_b, 8'h11);
        check("col_cnt_nb", cnt_nb, 8'd2);
        check("col_cnt_b", cnt_b, 8'd2);

        // Both ports writing different registers: R0 forwards R0Value, reg6 forwards WriteValue.
        WriteEn = 1'b1; WriteReg = 3'd6; WriteValue = 8'h66;
        R0WriteEn = 1'b1; R0Value = 8'h5A; ReadReg1 = 3'd0;
        #1;
        check("dual_rd1_r0_b", rd1_b, 8'h5A);
        check("dual_r0_b", r0_b, 8'h5A);
        check("dual_rd1_r0_nb", rd1_nb, 8'h11);
        ReadReg1 = 3'd6;
        #1;
        check("dual_rd1_r6_b", rd1_b, 8'h66);
        tick();
        idle_inputs();
        #1;
        check("dual_next_r6_nb", rd1_nb, 8'h66);
        check("dual_next_r0_nb", r0_nb, 8'h5A);
        check("dual_cnt_nb", cnt_nb, 8'd3);

        // Reset mid-operation: reg5=3C, then reset cycle with a write to reg5.
        WriteEn = 1'b1; WriteReg = 3'd5; WriteValue = 8'h3C; ReadReg1 = 3'd5;
        tick();
        idle_inputs();
        #1;
        check("r5_pre_nb", rd1_nb, 8'h3C);
        check("r5_cnt_nb", cnt_nb, 8'd4);
        Reset = 1'b1; WriteEn = 1'b1; WriteReg = 3'd5; WriteValue = 8'hFF;
        R0WriteEn = 1'b1; R0Value = 8'h77;
        #1;
        check("rstw_nofwd_rd1_b", rd1_b, 8'h3C);
        check("rstw_nofwd_r0_b", r0_b, 8'h5A);
        tick();
        Reset = 1'b0;
        idle_inputs();
        #1;
        check("rstw_r5_nb", rd1_nb, 8'h00);
        check("rstw_r5_b", rd1_b, 8'h00);
        check("rstw_r0_b", r0_b, 8'h00);
        check("rstw_cnt_nb", cnt_nb, 8'd0);
        check("rstw_cnt_b", cnt_b, 8'd0);
        ReadReg1 = 3'd3;
        #1;
        check("rstw_r3_nb", rd1_nb, 8'h00);
        ReadReg1 = 3'd6;
        #1;
        check("rstw_r6_b", rd1_b, 8'h00);

        // Counter saturation: 300 consecutive R0 writes of data 0..299 (mod 256).
        for (int i = 0; i < 300; i++) begin
            R0WriteEn = 1'b1;
            R0Value   = 8'(i);
            tick();
            if (i == 253) begin
                check("sat_cnt_254", cnt_nb, 8'd254);
            end
            if (i == 254) begin
                check("sat_cnt_255", cnt_nb, 8'd255);
            end
        end
        idle_inputs();
        #1;
        check("sat_cnt_nb", cnt_nb, 8'd255);
        check("sat_cnt_b", cnt_b, 8'd255);
        check("sat_r0_nb", r0_nb, 8'h2B);
        check("sat_r0_b", r0_b, 8'h2B);
        tick();
        check("sat_hold_idle", cnt_nb, 8'd255);
        WriteEn = 1'b1; WriteReg = 3'd2; WriteValue = 8'h9E;
        tick();
        idle_inputs();
        #1;
        check("sat_hold_wr", cnt_b, 8'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- Architectural register file that sits directly downstream of the write-back select mux and consumes its 8-bit output as the write data.
- Holds NREGS registers of width W.
- Provides two read ports:
  - R0 on a dedicated port, feeding the mux's Source1 path.
  - One addressed port, feeding the mux's Source2 path.
- Provides two write ports: a general write-back port and a dedicated R0 accumulator port.
- Optional same-cycle read-after-write bypass.

Parameters:
- W, 8, data width of every register.
- NREGS, 8, number of registers; must be a power of two, at least 2.
- AW, $clog2(NREGS), address width (derived, not overridden).
- BYPASS, 1, 1 = read ports forward same-cycle write data; 0 = reads return the stored value only.

Ports:
- Clk  input  1  system clock; all state updates on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- ReadReg1  input  AW  address for read port 1.
- WriteEn  input  1  general write enable.
- WriteReg  input  AW  general write address.
- WriteValue  input  W  general write data (from write-back mux output).
- R0WriteEn  input  1  dedicated R0 write enable.
- R0Value  input  W  dedicated R0 write data.
- ReadR0  output  W  current R0 value.
- ReadData1  output  W  value of register ReadReg1.
- WriteCount  output  8  number of committed writes since reset; saturates at 255.

Behaviour:
- Reset:
  - Reset is synchronous, active-high; clock is Clk, reset is Reset.
  - When Reset=1 at a rising edge, every register, including R0, becomes 0 and WriteCount becomes 0.
  - All writes asserted in that cycle are discarded.
- Reads:
  - ReadR0 and ReadData1 are combinational from the array, with zero read latency.
  - After the reset edge both read as 0 until written.
- General write:
  - If WriteEn=1, reg[WriteReg] <= WriteValue at the next edge.
  - Write-to-read latency is 1 cycle when BYPASS=0.
- R0 write: if R0WriteEn=1, reg[0] <= R0Value at the next edge.
- Collision (WriteEn=1, WriteReg=0, R0WriteEn=1 in the same cycle):
  - The general port wins; R0 takes WriteValue and R0Value is dropped.
  - WriteCount increments by 1, not 2.
- Bypass (BYPASS=1), forwarding priority:
  - If ReadReg1 equals WriteReg and WriteEn=1, ReadData1 = WriteValue.
  - Else if ReadReg1=0 and R0WriteEn=1, ReadData1 = R0Value.
  - Else ReadData1 = the stored value.
  - ReadR0 follows the same rules with address 0, including the collision priority.
  - Bypass is suppressed while Reset=1: outputs show stored contents.
- WriteCount:
  - +1 per edge on which at least one write commits (Reset=0 and (WriteEn or R0WriteEn)).
  - Holds at 255; no wrap.
- No state machine beyond the array and counter.
- Reset mid-write: reset dominates and no register changes except to 0.
- Out-of-range addresses cannot occur because NREGS is a power of two.

Decomposition:
- Shared package holds:
  - W and NREGS defaults.
  - typedef logic [W-1:0] word_t.
  - typedef logic [AW-1:0] regaddr_t.
  - Constant R0_ADDR = 0.
  - Constant WCOUNT_MAX = 255.
- One natural sub-module, rf_bypass: purely combinational forwarding selector, instantiated once per read port.
- The array and counter stay in reg_file_wb.

Test Plan:
- Reset then idle: assert Reset 1 cycle, ReadReg1 swept 0..7 -> ReadData1=0 for all addresses; ReadR0=0; WriteCount=0.
- Basic write/read (BYPASS=0): WriteEn=1, WriteReg=3, WriteValue=8'hA5 for 1 cycle.
  - Same cycle, ReadReg1=3 -> 8'h00.
  - Next cycle -> 8'hA5; WriteCount=1.
- Bypass (BYPASS=1): the same stimulus -> ReadData1=8'hA5 in the write cycle itself.
- Collision: WriteEn=1, WriteReg=0, WriteValue=8'h11, R0WriteEn=1, R0Value=8'h22.
  - Next cycle ReadR0=8'h11.
  - WriteCount incremented by exactly 1.
  - With BYPASS=1, ReadR0=8'h11 in the same cycle.
- Reset mid-operation: reg5=8'h3C, then a cycle with Reset=1, WriteEn=1, WriteReg=5, WriteValue=8'hFF.
  - Next cycle ReadData1(5)=8'h00 and WriteCount=0.
- Counter saturation: 300 consecutive R0 writes of incrementing data.
  - WriteCount=255 and stays there.
  - ReadR0 equals the last value written (300 mod 256 - 1 = 8'h2B).
